toy_trap_seq: RTL and testbench
===============================

Name: toy_trap_seq

Overview:
Trap/debug entry sequencer directly downstream of the trap arbitration stage. It accepts one normal trap, debug entry, mret or dret event at a time, and flushes the pipeline. It then waits for the pipeline to drain, commits the machine-mode or debug-mode CSR state in a single cycle, and issues one fetch redirect with a valid/ready handshake. It owns mepc, mcause, mtval, mstatus.MIE/MPIE, dpc, dcsr.cause and the debug-mode flag.

Parameters:
ADDR_WIDTH, 32, PC/redirect width
INST_WIDTH, 32, trap extra-info (mtval source) width
REG_WIDTH, 32, CSR width
DEBUG_ENTRY_PC, 32'h0000_0800, debug ROM entry (halt/ebreak/step)
DEBUG_EXCP_PC, 32'h0000_0808, target for an exception taken while in debug mode

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
trap_vld  in  1  normal trap request
trap_rdy  out  1  trap accepted this cycle when trap_vld&&trap_rdy
trap_pc  in  ADDR_WIDTH  faulting PC
trap_cause  in  32  mcause value
trap_extra_info  in  INST_WIDTH  mtval value
trap_indebug  in  1  trap raised while in debug mode
debug_vld  in  1  debug entry request; held by source until debug_ack
debug_ack  out  1  one-cycle pulse: debug request accepted
debug_cause  in  3  dcsr.cause code
debug_pc  in  ADDR_WIDTH  dpc value
mret_vld  in  1  mret retiring; held until ret_ack
dret_vld  in  1  dret retiring; held until ret_ack
ret_ack  out  1  one-cycle pulse: mret/dret accepted
pipe_idle  in  1  no instruction in flight after flush
csr_mtvec  in  REG_WIDTH  trap vector base (direct mode only)
flush  out  1  pipeline kill, one cycle
redirect_vld  out  1  fetch redirect valid
redirect_pc  out  ADDR_WIDTH  fetch target
redirect_rdy  in  1  fetch accepted redirect
busy  out  1  state != IDLE
csr_mepc  out  ADDR_WIDTH  mepc
csr_mcause  out  32  mcause
csr_mtval  out  REG_WIDTH  mtval
csr_mstatus_mie  out  1  mstatus.MIE
csr_mstatus_mpie  out  1  mstatus.MPIE
csr_dpc  out  ADDR_WIDTH  dpc
csr_dcsr_cause  out  3  dcsr.cause
debug_mode_en  out  1  hart in debug mode

Behaviour:
- Reset: state IDLE. All CSR outputs are 0, as are debug_mode_en, flush, redirect_vld, redirect_pc, debug_ack, ret_ack and busy. Reset mid-sequence aborts the sequence with no redirect.
- FSM: IDLE -> DRAIN -> COMMIT -> REDIRECT -> IDLE.
- Acceptance happens in IDLE only. Priority is debug_vld > trap_vld > dret_vld > mret_vld, one event per cycle.
  - trap_rdy = (state==IDLE) && !debug_vld, combinational.
  - debug_ack and ret_ack are combinational pulses in the accept cycle.
- dret_vld with debug_mode_en=0 is not accepted. ret_ack stays low and the request is ignored.
- On accept, the event type and payload are latched; later input changes are ignored. Next state is DRAIN.
- DRAIN: flush=1 in the first DRAIN cycle only. The block stays in DRAIN until pipe_idle=1 is sampled, which may be in the first DRAIN cycle, then moves to COMMIT.
- COMMIT lasts one cycle; registers update at its end.
  - Normal trap (trap_indebug=0):
    - mepc <= trap_pc; mcause <= trap_cause.
    - mtval <= trap_extra_info, zero-extended/truncated to REG_WIDTH.
    - mpie <= mie; mie <= 0.
    - Target {csr_mtvec[ADDR_WIDTH-1:2],2'b00}, with csr_mtvec sampled in COMMIT.
  - Trap with trap_indebug=1: no CSR change; target DEBUG_EXCP_PC.
  - Debug entry:
    - dpc <= debug_pc; dcsr_cause <= debug_cause; debug_mode_en <= 1.
    - m-mode CSRs are untouched.
    - Target DEBUG_ENTRY_PC.
  - mret: mie <= mpie; mpie <= 1; target mepc.
  - dret: debug_mode_en <= 0; target dpc.
- REDIRECT: redirect_vld=1 with redirect_pc registered and stable until redirect_rdy. On handshake the block returns to IDLE the next cycle.
- busy = 1 in DRAIN/COMMIT/REDIRECT. A new event can be accepted in the cycle after the REDIRECT handshake completes.
- Minimum latency with pipe_idle=1 and redirect_rdy=1 (accept in cycle N):
  - flush in N+1.
  - COMMIT in N+2.
  - redirect_vld in N+3; IDLE in N+4.

Test Plan:
- Normal trap: trap_vld, trap_pc=0x1000_0040, cause=2, info=0xFFFF_FFFF, mie=1, mtvec=0x8000_0103, pipe_idle=1, redirect_rdy=1 -> trap_rdy in N, flush in N+1, mepc=0x1000_0040, mcause=2, mtval=0xFFFF_FFFF, mie=0, mpie=1, redirect_pc=0x8000_0100 in N+3.
- Simultaneous debug_vld (cause 3, debug_pc=0x200) and trap_vld -> trap_rdy=0, debug_ack=1, dpc=0x200, dcsr_cause=3, debug_mode_en=1, redirect_pc=0x800; trap accepted after return to IDLE.
- Drain stall: pipe_idle low 5 cycles after flush -> flush exactly one cycle, COMMIT one cycle after pipe_idle rises, CSRs unchanged before then.
- Redirect backpressure: redirect_rdy low 4 cycles -> redirect_vld and redirect_pc stable, trap_rdy=0 throughout.
- Debug round trip: debug entry, then trap_indebug trap -> redirect 0x808, mepc unchanged; dret -> debug_mode_en=0, redirect_pc=dpc. dret outside debug mode -> no ret_ack, no flush.
- mret after trap -> mie=1, mpie=1, redirect_pc=mepc. rst_n asserted during DRAIN -> all outputs 0, state IDLE, no redirect.

Source files
------------

// File: rtl/toy_trap_seq.sv
// toy_trap_seq: trap/debug entry sequencer (accept -> flush/drain -> CSR commit -> fetch redirect)
// Ports: trap_*/debug_*/mret_vld/dret_vld accept events in IDLE; pipe_idle ends drain;
// redirect_* is the fetch handshake; csr_* and debug_mode_en are the architectural state owned here.
module toy_trap_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int REG_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] DEBUG_ENTRY_PC = 'h0000_0800,
  parameter logic [ADDR_WIDTH-1:0] DEBUG_EXCP_PC = 'h0000_0808
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trap_vld,
  output logic                  trap_rdy,
  input  logic [ADDR_WIDTH-1:0] trap_pc,
  input  logic [31:0]           trap_cause,
  input  logic [INST_WIDTH-1:0] trap_extra_info,
  input  logic                  trap_indebug,
  input  logic                  debug_vld,
  output logic                  debug_ack,
  input  logic [2:0]            debug_cause,
  input  logic [ADDR_WIDTH-1:0] debug_pc,
  input  logic                  mret_vld,
  input  logic                  dret_vld,
  output logic                  ret_ack,
  input  logic                  pipe_idle,
  input  logic [REG_WIDTH-1:0]  csr_mtvec,
  output logic                  flush,
  output logic                  redirect_vld,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  redirect_rdy,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] csr_mepc,
  output logic [31:0]           csr_mcause,
  output logic [REG_WIDTH-1:0]  csr_mtval,
  output logic                  csr_mstatus_mie,
  output logic                  csr_mstatus_mpie,
  output logic [ADDR_WIDTH-1:0] csr_dpc,
  output logic [2:0]            csr_dcsr_cause,
  output logic                  debug_mode_en
);
  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
  typedef enum logic [1:0] {EV_TRAP, EV_DBG, EV_MRET, EV_DRET} ev_t;
  state_t state;
  ev_t ev;
  logic [ADDR_WIDTH-1:0] l_pc;
  logic [31:0] l_cause;
  logic [INST_WIDTH-1:0] l_info;
  logic l_indebug;
  logic idle, acc_dbg, acc_trap, acc_dret, acc_mret;
  assign idle = state == IDLE;
  assign trap_rdy = idle && !debug_vld;
  assign acc_dbg = idle && debug_vld;
  assign acc_trap = trap_rdy && trap_vld;
  // dret outside debug mode is simply not accepted, so it cannot block a pending mret
  assign acc_dret = trap_rdy && !trap_vld && dret_vld && debug_mode_en;
  assign acc_mret = trap_rdy && !trap_vld && !acc_dret && mret_vld;
  assign debug_ack = acc_dbg;
  assign ret_ack = acc_dret || acc_mret;
  assign busy = !idle;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ev <= EV_TRAP;
      l_pc <= '0;
      l_cause <= '0;
      l_info <= '0;
      l_indebug <= 1'b0;
      flush <= 1'b0;
      redirect_vld <= 1'b0;
      redirect_pc <= '0;
      csr_mepc <= '0;
      csr_mcause <= '0;
      csr_mtval <= '0;
      csr_mstatus_mie <= 1'b0;
      csr_mstatus_mpie <= 1'b0;
      csr_dpc <= '0;
      csr_dcsr_cause <= '0;
      debug_mode_en <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc_dbg || acc_trap || acc_dret || acc_mret) begin
          state <= DRAIN;
          flush <= 1'b1;
          ev <= acc_dbg ? EV_DBG : acc_trap ? EV_TRAP : acc_dret ? EV_DRET : EV_MRET;
          l_pc <= acc_dbg ? debug_pc : trap_pc;
          l_cause <= acc_dbg ? 32'(debug_cause) : trap_cause;
          l_info <= trap_extra_info;
          l_indebug <= trap_indebug;
        end
        DRAIN: begin
          flush <= 1'b0;
          if (pipe_idle) state <= COMMIT;
        end
        COMMIT: begin
          state <= REDIRECT;
          redirect_vld <= 1'b1;
          case (ev)
            EV_TRAP: if (l_indebug) redirect_pc <= DEBUG_EXCP_PC;
            else begin
              csr_mepc <= l_pc;
              csr_mcause <= l_cause;
              csr_mtval <= REG_WIDTH'(l_info);
              csr_mstatus_mpie <= csr_mstatus_mie;
              csr_mstatus_mie <= 1'b0;
              redirect_pc <= csr_mtvec[ADDR_WIDTH-1:0] & ~ADDR_WIDTH'(3);
            end
            EV_DBG: begin
              csr_dpc <= l_pc;
              csr_dcsr_cause <= l_cause[2:0];
              debug_mode_en <= 1'b1;
              redirect_pc <= DEBUG_ENTRY_PC;
            end
            EV_MRET: begin
              csr_mstatus_mie <= csr_mstatus_mpie;
              csr_mstatus_mpie <= 1'b1;
              redirect_pc <= csr_mepc;
            end
            EV_DRET: begin
              debug_mode_en <= 1'b0;
              redirect_pc <= csr_dpc;
            end
          endcase
        end
        REDIRECT: if (redirect_rdy) begin
          redirect_vld <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_toy_trap_seq.sv
// tb_toy_trap_seq: directed self-checking bench for toy_trap_seq
module tb_toy_trap_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  logic trap_vld = 1'b0, trap_rdy, trap_indebug = 1'b0;
  logic [31:0] trap_pc = '0, trap_cause = '0, trap_extra_info = '0;
  logic debug_vld = 1'b0, debug_ack;
  logic [2:0] debug_cause = '0;
  logic [31:0] debug_pc = '0;
  logic mret_vld = 1'b0, dret_vld = 1'b0, ret_ack;
  logic pipe_idle = 1'b1, redirect_rdy = 1'b1;
  logic [31:0] csr_mtvec = '0;
  logic flush, redirect_vld, busy;
  logic [31:0] redirect_pc, csr_mepc, csr_mcause, csr_mtval, csr_dpc;
  logic csr_mstatus_mie, csr_mstatus_mpie, debug_mode_en;
  logic [2:0] csr_dcsr_cause;
  int n_chk = 0, n_err = 0;
  toy_trap_seq dut (
    .clk(clk), .rst_n(rst_n), .trap_vld(trap_vld), .trap_rdy(trap_rdy), .trap_pc(trap_pc),
    .trap_cause(trap_cause), .trap_extra_info(trap_extra_info), .trap_indebug(trap_indebug),
    .debug_vld(debug_vld), .debug_ack(debug_ack), .debug_cause(debug_cause), .debug_pc(debug_pc),
    .mret_vld(mret_vld), .dret_vld(dret_vld), .ret_ack(ret_ack), .pipe_idle(pipe_idle),
    .csr_mtvec(csr_mtvec), .flush(flush), .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .redirect_rdy(redirect_rdy), .busy(busy), .csr_mepc(csr_mepc), .csr_mcause(csr_mcause),
    .csr_mtval(csr_mtval), .csr_mstatus_mie(csr_mstatus_mie), .csr_mstatus_mpie(csr_mstatus_mpie),
    .csr_dpc(csr_dpc), .csr_dcsr_cause(csr_dcsr_cause), .debug_mode_en(debug_mode_en)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " flags"}, 32'({flush, redirect_vld, busy, debug_ack, ret_ack, csr_mstatus_mie,
        csr_mstatus_mpie, debug_mode_en, csr_dcsr_cause}), 32'h0);
    chk({tag, " mepc"}, csr_mepc, 32'h0);
    chk({tag, " mcause"}, csr_mcause, 32'h0);
    chk({tag, " mtval"}, csr_mtval, 32'h0);
    chk({tag, " dpc"}, csr_dpc, 32'h0);
    chk({tag, " rpc"}, redirect_pc, 32'h0);
  endtask
  task automatic mret_seq(input logic [31:0] exp_pc, input logic exp_mie);
    mret_vld = 1'b1;
    #1 chk("mret ack", 32'(ret_ack), 32'h1);
    step();
    mret_vld = 1'b0;
    chk("mret flush", 32'(flush), 32'h1);
    step();
    step();
    chk("mret rvld", 32'(redirect_vld), 32'h1);
    chk("mret rpc", redirect_pc, exp_pc);
    chk("mret mie", 32'(csr_mstatus_mie), 32'(exp_mie));
    chk("mret mpie", 32'(csr_mstatus_mpie), 32'h1);
    step();
    chk("mret idle", 32'(busy), 32'h0);
  endtask
  initial begin
    #1 chk_zero("reset");
    step();
    rst_n = 1'b1;
    step();
    chk("idle rdy", 32'(trap_rdy), 32'h1);
    mret_seq(32'h0, 1'b0);
    mret_seq(32'h0, 1'b1);
    // normal trap, minimum latency
    trap_vld = 1'b1; trap_pc = 32'h1000_0040; trap_cause = 32'd2;
    trap_extra_info = 32'hFFFF_FFFF; csr_mtvec = 32'h8000_0103;
    #1 chk("trap rdy", 32'(trap_rdy), 32'h1);
    step();
    trap_vld = 1'b0; trap_pc = 32'hDEAD_BEEF; trap_cause = 32'd9;
    chk("trap flush", 32'(flush), 32'h1);
    chk("trap busy", 32'(busy), 32'h1);
    step();
    chk("trap commit flush", 32'(flush), 32'h0);
    chk("trap commit rvld", 32'(redirect_vld), 32'h0);
    chk("trap commit mepc", csr_mepc, 32'h0);
    step();
    chk("trap rvld", 32'(redirect_vld), 32'h1);
    chk("trap rpc", redirect_pc, 32'h8000_0100);
    chk("trap mepc", csr_mepc, 32'h1000_0040);
    chk("trap mcause", csr_mcause, 32'd2);
    chk("trap mtval", csr_mtval, 32'hFFFF_FFFF);
    chk("trap mie", 32'(csr_mstatus_mie), 32'h0);
    chk("trap mpie", 32'(csr_mstatus_mpie), 32'h1);
    step();
    chk("trap idle", 32'({busy, redirect_vld}), 32'h0);
    mret_seq(32'h1000_0040, 1'b1);
    // debug entry beats a simultaneous trap; the trap waits and is taken in debug mode
    debug_vld = 1'b1; debug_cause = 3'd3; debug_pc = 32'h200;
    trap_vld = 1'b1; trap_pc = 32'h3000; trap_cause = 32'd7; trap_indebug = 1'b1;
    #1 chk("dbg trap_rdy", 32'(trap_rdy), 32'h0);
    chk("dbg ack", 32'(debug_ack), 32'h1);
    step();
    debug_vld = 1'b0; debug_pc = 32'h999;
    chk("dbg flush", 32'(flush), 32'h1);
    chk("dbg busy trap_rdy", 32'(trap_rdy), 32'h0);
    step();
    step();
    chk("dbg rpc", redirect_pc, 32'h800);
    chk("dbg dpc", csr_dpc, 32'h200);
    chk("dbg cause", 32'(csr_dcsr_cause), 32'd3);
    chk("dbg mode", 32'(debug_mode_en), 32'h1);
    chk("dbg mepc", csr_mepc, 32'h1000_0040);
    step();
    chk("held trap rdy", 32'(trap_rdy), 32'h1);
    step();
    trap_vld = 1'b0;
    chk("dtrap flush", 32'(flush), 32'h1);
    step();
    redirect_rdy = 1'b0;
    step();
    trap_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp rvld", 32'(redirect_vld), 32'h1);
      chk("bp rpc", redirect_pc, 32'h808);
      chk("bp trap_rdy", 32'(trap_rdy), 32'h0);
      if (i == 4) begin
        redirect_rdy = 1'b1;
        trap_vld = 1'b0;
      end
      step();
    end
    chk("bp idle", 32'({busy, redirect_vld}), 32'h0);
    chk("dtrap mepc", csr_mepc, 32'h1000_0040);
    chk("dtrap mcause", csr_mcause, 32'd2);
    trap_indebug = 1'b0;
    // dret leaves debug mode
    dret_vld = 1'b1;
    #1 chk("dret ack", 32'(ret_ack), 32'h1);
    step();
    dret_vld = 1'b0;
    chk("dret flush", 32'(flush), 32'h1);
    step();
    step();
    chk("dret rpc", redirect_pc, 32'h200);
    chk("dret mode", 32'(debug_mode_en), 32'h0);
    step();
    dret_vld = 1'b1;
    #1 chk("dret nodbg ack", 32'(ret_ack), 32'h0);
    step();
    chk("dret nodbg flush", 32'({flush, busy}), 32'h0);
    dret_vld = 1'b0;
    // drain stall
    pipe_idle = 1'b0;
    trap_vld = 1'b1; trap_pc = 32'h2000; trap_cause = 32'd5; trap_extra_info = 32'h12;
    step();
    trap_vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("stall flush", 32'(flush), 32'(i == 0));
      chk("stall rvld", 32'(redirect_vld), 32'h0);
      chk("stall mepc", csr_mepc, 32'h1000_0040);
      if (i == 5) pipe_idle = 1'b1;
      step();
    end
    chk("stall commit rvld", 32'(redirect_vld), 32'h0);
    chk("stall commit mepc", csr_mepc, 32'h1000_0040);
    step();
    chk("stall rvld", 32'(redirect_vld), 32'h1);
    chk("stall rpc", redirect_pc, 32'h8000_0100);
    chk("stall mepc", csr_mepc, 32'h2000);
    chk("stall mcause", csr_mcause, 32'd5);
    chk("stall mtval", csr_mtval, 32'h12);
    chk("stall mie/mpie", 32'({csr_mstatus_mie, csr_mstatus_mpie}), 32'h1);
    step();
    // reset in the middle of DRAIN
    pipe_idle = 1'b0;
    trap_vld = 1'b1;
    step();
    trap_vld = 1'b0;
    chk("rst pre busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1 chk_zero("midrst");
    step();
    rst_n = 1'b1;
    pipe_idle = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post rst", 32'({busy, redirect_vld, flush}), 32'h0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
